// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Two-entry valid/ready pipeline stage. It has a main register and a skid
// register, and each one holds a payload and a memory-access flag. The upstream
// ready signal comes only from state flops, so there is no combinational path
// from dn_ready_i to up_ready_o. The stage still sustains one entry per cycle:
// when downstream stalls, the skid register catches the entry that was already
// in flight. flush_i discards everything the stage holds. A saturating counter
// records the cycles in which downstream applies back-pressure.
//
// Parameters
//   DW      payload width in bits (1..512)
//   BUBBLE  value shown on dn_data_o while no entry is valid
//   CNT_W   width of the back-pressure counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   flush_i      discard all held entries; wins over push/pop
//   up_valid_i   upstream entry valid
//   up_ready_o   stage can accept (registered)
//   up_data_i    upstream payload
//   up_mem_i     upstream entry is a load/store
//   dn_valid_o   downstream entry valid (registered)
//   dn_ready_i   downstream accepts
//   dn_data_o    presented payload (main register)
//   dn_mem_o     memory-access flag of presented entry
//   occ_o        entries held, 0..2
//   stall_cnt_o  saturating count of dn_valid_o & !dn_ready_i cycles
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int             DW     = 64,
  parameter logic [DW-1:0]  BUBBLE = {DW{1'b0}},
  parameter int             CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [DW-1:0]    up_data_i,
  input  logic             up_mem_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [DW-1:0]    dn_data_o,
  output logic             dn_mem_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // The state encoding is the occupancy, so occ_o is just the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     main_data_q, main_data_d;
  logic              main_mem_q,  main_mem_d;
  logic [DW-1:0]     skid_data_q, skid_data_d;
  logic              skid_mem_q,  skid_mem_d;
  logic              up_ready_q;
  logic              dn_valid_q;
  logic [CNT_W-1:0]  stall_q;

  logic push;
  logic pop;

  assign push = up_valid_i & up_ready_q;
  assign pop  = dn_valid_q & dn_ready_i;

  // Next-state and datapath selection.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_mem_d  = main_mem_q;
    skid_data_d = skid_data_q;
    skid_mem_d  = skid_mem_q;

    if (flush_i) begin
      // A flush drops any entry offered in the same cycle.
      state_d     = EMPTY;
      main_data_d = BUBBLE;
      main_mem_d  = 1'b0;
      skid_data_d = BUBBLE;
      skid_mem_d  = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = up_data_i;
            main_mem_d  = up_mem_i;
          end
        end
        ONE: begin
          if (push && !pop) begin
            // The downstream stalled while an entry was in flight, so the skid
            // register takes the new entry.
            state_d     = FULL;
            skid_data_d = up_data_i;
            skid_mem_d  = up_mem_i;
          end else if (!push && pop) begin
            // Load BUBBLE so the output shows it while the stage is empty.
            state_d     = EMPTY;
            main_data_d = BUBBLE;
            main_mem_d  = 1'b0;
          end else if (push && pop) begin
            main_data_d = up_data_i;
            main_mem_d  = up_mem_i;
          end
        end
        FULL: begin
          // up_ready_o is low here, so there can be no push in this state.
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_mem_d  = skid_mem_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = BUBBLE;
          main_mem_d  = 1'b0;
        end
      endcase
    end
  end

  // State, handshake outputs and the stall counter.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses a non-blocking assignment, so all of them
    // update from values sampled at the same edge.
    if (!rst_n) begin
      // NOTE: the payload registers are reset as well, because the output
      // must show BUBBLE from the first cycle after reset.
      state_q     <= EMPTY;
      main_data_q <= BUBBLE;
      main_mem_q  <= 1'b0;
      skid_data_q <= BUBBLE;
      skid_mem_q  <= 1'b0;
      up_ready_q  <= 1'b1;
      dn_valid_q  <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_mem_q  <= main_mem_d;
      skid_data_q <= skid_data_d;
      skid_mem_q  <= skid_mem_d;
      up_ready_q  <= (state_d != FULL);
      dn_valid_q  <= (state_d != EMPTY);
      // flush_i does not affect this counter; it only counts back-pressure.
      if (dn_valid_q && !dn_ready_i && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign up_ready_o  = up_ready_q;
  assign dn_valid_o  = dn_valid_q;
  assign dn_data_o   = main_data_q;
  assign dn_mem_o    = main_mem_q;
  assign occ_o       = state_q;
  assign stall_cnt_o = stall_q;

endmodule
